// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 signed max-pool over a raster-order feature map.
// Even rows fold into a half-width line buffer; odd rows emit through one output register.
module maxpool2x2_stream #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28
) (
  input  logic                     clock_in,
  input  logic                     rst_n,
  input  logic                     tick,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  input  logic                     out_ready,
  output logic                     frame_done
);

  localparam int unsigned ColW  = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW  = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int unsigned BufD  = IMG_W / 2;
  localparam int unsigned BufAw = (BufD > 1) ? $clog2(BufD) : 1;

  logic [ColW-1:0]          col_q, col_d;
  logic [RowW-1:0]          row_q, row_d;
  logic signed [DATA_W-1:0] pair_q;
  logic signed [DATA_W-1:0] out_data_q;
  logic                     out_valid_q;
  logic                     frame_done_q;
  logic signed [DATA_W-1:0] line_buf_q [BufD];

  logic                     accept;
  logic                     col_last;
  logic                     row_last;
  logic                     load_result;
  logic [BufAw-1:0]         buf_idx;
  logic signed [DATA_W-1:0] buf_rd;
  logic signed [DATA_W-1:0] hmax;
  logic signed [DATA_W-1:0] vmax;

  // Stall only while a result is pending and downstream is not taking it.
  assign in_ready    = !(out_valid_q && !out_ready);
  assign accept      = tick && in_valid && in_ready;
  assign col_last    = (col_q == ColW'(IMG_W - 1));
  assign row_last    = (row_q == RowW'(IMG_H - 1));
  assign load_result = accept && col_q[0] && row_q[0];
  assign buf_idx     = BufAw'(col_q >> 1);
  assign buf_rd      = line_buf_q[buf_idx];
  assign hmax        = (in_data > pair_q) ? in_data : pair_q;
  assign vmax        = (hmax > buf_rd) ? hmax : buf_rd;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      pair_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (accept && !col_q[0]) begin
        pair_q <= in_data;
      end
      // A fresh load wins over the clearing handshake on the same edge.
      if (load_result) begin
        out_data_q  <= vmax;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      frame_done_q <= load_result && col_last && row_last;
    end
  end

  // Line buffer holds don't-care data after reset, so it is left unreset.
  always_ff @(posedge clock_in) begin
    if (accept && col_q[0] && !row_q[0]) begin
      line_buf_q[buf_idx] <= hmax;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Bench for maxpool2x2_stream: 4x4 instance driven against a reference block-max model,
// plus a 2x2 instance for the signed corner case.
module tb_maxpool2x2_stream;

  logic clk = 1'b0;
  logic rst_n;

  logic              tick, in_valid, in_ready, out_valid, out_ready, frame_done;
  logic signed [7:0] in_data, out_data;
  logic              tick2, in_valid2, in_ready2, out_valid2, out_ready2, frame_done2;
  logic signed [7:0] in_data2, out_data2;

  typedef struct packed {
    logic       fd;
    logic [7:0] val;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb2_q[$];

  int         checks   = 0;
  int         failures = 0;
  int         fd_count = 0;
  int         m_row    = 0;
  int         m_col    = 0;
  logic [7:0] img [4][4];
  logic       exp_ov   = 1'b0;
  logic       exp_fd   = 1'b0;
  logic [7:0] exp_od   = '0;

  always #5 clk = ~clk;

  maxpool2x2_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) u_dut (
    .clock_in   (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .frame_done (frame_done)
  );

  maxpool2x2_stream #(.DATA_W(8), .IMG_W(2), .IMG_H(2)) u_dut2 (
    .clock_in   (clk),
    .rst_n      (rst_n),
    .tick       (tick2),
    .in_valid   (in_valid2),
    .in_data    (in_data2),
    .in_ready   (in_ready2),
    .out_valid  (out_valid2),
    .out_data   (out_data2),
    .out_ready  (out_ready2),
    .frame_done (frame_done2)
  );

  function automatic logic [7:0] smax(input logic [7:0] a, input logic [7:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // One clock of stimulus on the 4x4 instance; updates the reference model, samples at edge+1.
  task automatic drive_cycle(input logic tk, input logic iv, input logic [7:0] d,
                             input logic ordy, output logic acc, output logic ir);
    logic res;
    exp_t e;
    tick      = tk;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    ir  = in_ready;
    acc = tk && iv && ir;
    res = 1'b0;
    if (acc) begin
      img[m_row][m_col] = d;
      if (m_row % 2 == 1 && m_col % 2 == 1) begin
        e.val = smax(smax(img[m_row-1][m_col-1], img[m_row-1][m_col]),
                     smax(img[m_row][m_col-1], d));
        e.fd  = (m_row == 3 && m_col == 3);
        sb_q.push_back(e);
        res = 1'b1;
      end
      if (m_col == 3) begin
        m_col = 0;
        m_row = (m_row == 3) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
    @(posedge clk);
    #1;
    if (res) begin
      e      = sb_q.pop_front();
      exp_ov = 1'b1;
      exp_od = e.val;
      exp_fd = e.fd;
    end else begin
      if (ordy) exp_ov = 1'b0;
      exp_fd = 1'b0;
    end
    if (frame_done) fd_count++;
  endtask

  task automatic run_stream(input string name, input int nframes, input int base0,
                            input int base1, input int period, input int stall_cycles);
    int p, phase, cyc, stall_left, total, limit;
    logic acc, ir, ordy, exp_ir;
    logic [7:0] d;
    p = 0; phase = 0; cyc = 0; stall_left = stall_cycles;
    total = nframes * 16;
    limit = total * period + stall_cycles + 40;
    fd_count = 0;
    while (p < total && cyc < limit) begin
      d = 8'(((p / 16 == 0) ? base0 : base1) + p % 16);
      ordy = 1'b1;
      if (stall_left > 0 && exp_ov && p >= 6) begin
        ordy = 1'b0;
        stall_left--;
      end
      exp_ir = !(exp_ov && !ordy);
      drive_cycle((phase == period - 1), 1'b1, d, ordy, acc, ir);
      phase = (phase == period - 1) ? 0 : phase + 1;
      if (acc) p++;
      cyc++;
      checks++;
      if (ir !== exp_ir) begin
        failures++;
        $display("FAIL %s in_ready cyc=%0d got=%b exp=%b", name, cyc, ir, exp_ir);
      end
      checks++;
      if (out_valid !== exp_ov) begin
        failures++;
        $display("FAIL %s out_valid cyc=%0d got=%b exp=%b", name, cyc, out_valid, exp_ov);
      end
      if (exp_ov) begin
        checks++;
        if (out_data !== exp_od) begin
          failures++;
          $display("FAIL %s out_data cyc=%0d got=%0d exp=%0d", name, cyc,
                   $signed(out_data), $signed(exp_od));
        end
      end
      checks++;
      if (frame_done !== exp_fd) begin
        failures++;
        $display("FAIL %s frame_done cyc=%0d got=%b exp=%b", name, cyc, frame_done, exp_fd);
      end
    end
    checks++;
    if (p != total) begin
      failures++;
      $display("FAIL %s timeout pixels got=%0d exp=%0d", name, p, total);
    end
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 1'b0, 8'd0, 1'b1, acc, ir);
      checks++;
      if (out_valid !== exp_ov) begin
        failures++;
        $display("FAIL %s drain out_valid got=%b exp=%b", name, out_valid, exp_ov);
      end
    end
    checks++;
    if (fd_count != nframes) begin
      failures++;
      $display("FAIL %s frame_done_count got=%0d exp=%0d", name, fd_count, nframes);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
    #12;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (out_data !== 8'sd0) begin
      failures++; $display("FAIL reset out_data got=%0d exp=0", out_data);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      failures++; $display("FAIL reset frame_done got=%b exp=0", frame_done);
    end
    checks++;
    if (out_valid2 !== 1'b0) begin
      failures++; $display("FAIL reset out_valid2 got=%b exp=0", out_valid2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_raster();
    run_stream("raster", 1, 0, 0, 1, 0);
  endtask

  task automatic test_signed();
    logic [7:0] v [4];
    exp_t e;
    v = '{8'h80, 8'hFD, 8'hF9, 8'hFE};
    for (int i = 0; i < 4; i++) begin
      tick2 = 1'b1; in_valid2 = 1'b1; in_data2 = v[i]; out_ready2 = 1'b1;
      if (i == 3) begin
        e.val = smax(smax(v[0], v[1]), smax(v[2], v[3]));
        e.fd  = 1'b1;
        sb2_q.push_back(e);
      end
      @(posedge clk);
      #1;
      if (i < 3) begin
        checks++;
        if (out_valid2 !== 1'b0) begin
          failures++; $display("FAIL signed early out_valid i=%0d got=%b exp=0", i, out_valid2);
        end
      end
    end
    tick2 = 1'b0; in_valid2 = 1'b0;
    e = sb2_q.pop_front();
    checks++;
    if (out_valid2 !== 1'b1) begin
      failures++; $display("FAIL signed out_valid got=%b exp=1", out_valid2);
    end
    checks++;
    if (out_data2 !== e.val) begin
      failures++;
      $display("FAIL signed out_data got=%0d exp=%0d", $signed(out_data2), $signed(e.val));
    end
    checks++;
    if (frame_done2 !== e.fd) begin
      failures++; $display("FAIL signed frame_done got=%b exp=%b", frame_done2, e.fd);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid2 !== 1'b0 || frame_done2 !== 1'b0) begin
      failures++;
      $display("FAIL signed clear got=%b/%b exp=0/0", out_valid2, frame_done2);
    end
  endtask

  task automatic test_sparse_tick();
    run_stream("sparse_tick", 1, 0, 0, 38, 0);
  endtask

  task automatic test_backpressure();
    run_stream("backpressure", 1, 0, 0, 1, 5);
  endtask

  task automatic test_back_to_back();
    run_stream("back_to_back", 2, 0, 100, 1, 0);
  endtask

  task automatic test_reset_mid();
    logic acc, ir;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, 1'b1, 8'(i), 1'b0, acc, ir);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'sd5) begin
      failures++;
      $display("FAIL reset_mid pending got=%b/%0d exp=1/5", out_valid, out_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_mid out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_mid in_ready got=%b exp=1", in_ready);
    end
    m_row = 0; m_col = 0; exp_ov = 1'b0; exp_fd = 1'b0;
    sb_q.delete();
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_stream("after_reset", 1, 0, 0, 1, 0);
  endtask

  initial begin
    test_reset();
    test_raster();
    test_signed();
    test_sparse_tick();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
